// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
// Shared types and helpers for the branch target buffer.
//   btb_entry_t  : one table entry (valid, tag, target, jump, 2-bit counter)
//   CTR_*        : counter encodings used on allocate and reset
//   sat_update() : 2-bit saturating counter step (up when taken, else down)
// ---------------------------------------------------------------------------
package btb_pkg;

    // Widest tag the table can need (ENTRIES = 1 would leave 30 bits).
    // Narrower tags are stored zero-extended into this field.
    localparam int TAG_MAX_W = 30;

    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken
    localparam logic [1:0] CTR_RST = 2'b01;  // weakly not taken

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic                 jump;
        logic [1:0]           ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end else begin
            res = (ctr == 2'b00) ? ctr : ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// ---------------------------------------------------------------------------
// btb_sat_counter
// Combinational next-state of a 2-bit saturating direction counter.
// Ports:
//   ctr_i   : current counter value
//   taken_i : resolved direction (1 = count up, 0 = count down)
//   ctr_o   : next counter value, clamped to [0,3]
// ---------------------------------------------------------------------------
module btb_sat_counter
    import btb_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    assign ctr_o = sat_update(ctr_i, taken_i);

endmodule

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped BTB feeding the IF stage with the next fetch PC. Lookup is
// combinational on pc_IF; training from EX is written at the clock edge and
// becomes visible the following cycle (no same-cycle bypass).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pc_IF             : fetch PC being looked up
//   hit_IF            : valid entry with matching tag
//   taken_IF          : predict redirect (jump entry or counter MSB set)
//   nextpc_IF         : predicted target when taken, else pc_IF+4 (wraps)
//   upd_valid_EX      : resolved branch/jal/jalr present in EX
//   pc_EX, jump_EX    : PC of resolved instruction, 1 = unconditional
//   btaken_EX         : resolved direction of a conditional branch
//   target_EX         : resolved target address
//   stat_upd/hit/alloc: 32-bit wrapping event counters, only present when
//                       BTB_STATS_EN is defined
//
// The table is a flop array so every valid bit and counter clears in the
// single reset cycle; tags and targets are left unreset.
// ---------------------------------------------------------------------------
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_IF,
    output logic        hit_IF,
    output logic        taken_IF,
    output logic [31:0] nextpc_IF,
    input  logic        upd_valid_EX,
    input  logic [31:0] pc_EX,
    input  logic        jump_EX,
    input  logic        btaken_EX,
    input  logic [31:0] target_EX
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_upd,
    output logic [31:0] stat_hit,
    output logic [31:0] stat_alloc
`endif
);

    // Tags are kept zero-extended to the package's fixed tag field width.
    localparam int TAG_PAD = TAG_MAX_W - TAG_W;

    btb_entry_t table_rd [ENTRIES];

    // ---------------- lookup ----------------
    logic [IDX_W-1:0]     if_idx;
    logic [TAG_MAX_W-1:0] if_tag;
    btb_entry_t           if_entry;

    assign if_idx   = pc_IF[IDX_W+1:2];
    assign if_tag   = {{TAG_PAD{1'b0}}, pc_IF[31:IDX_W+2]};
    assign if_entry = table_rd[if_idx];

    // Outputs are forced to the fall-through PC while reset is held, since
    // the table itself only clears at the reset edge.
    assign hit_IF    = ~rst & if_entry.valid & (if_entry.tag == if_tag);
    assign taken_IF  = hit_IF & (if_entry.jump | if_entry.ctr[1]);
    assign nextpc_IF = taken_IF ? if_entry.target : pc_IF + 32'd4;

    // ---------------- update ----------------
    logic [IDX_W-1:0]     upd_idx;
    logic [TAG_MAX_W-1:0] upd_tag;
    btb_entry_t           upd_rd;
    logic                 upd_hit;
    logic                 upd_taken;
    logic                 upd_alloc;
    logic                 upd_wr_en;
    logic [1:0]           upd_ctr_next;
    btb_entry_t           upd_entry_d;

    assign upd_idx   = pc_EX[IDX_W+1:2];
    assign upd_tag   = {{TAG_PAD{1'b0}}, pc_EX[31:IDX_W+2]};
    assign upd_rd    = table_rd[upd_idx];
    assign upd_hit   = upd_rd.valid & (upd_rd.tag == upd_tag);
    assign upd_taken = jump_EX | btaken_EX;
    assign upd_alloc = upd_valid_EX & ~upd_hit & upd_taken;
    // A not-taken miss leaves the table untouched.
    assign upd_wr_en = upd_valid_EX & (upd_hit | upd_taken);

    btb_sat_counter u_sat_counter (
        .ctr_i   (upd_rd.ctr),
        .taken_i (upd_taken),
        .ctr_o   (upd_ctr_next)
    );

    always_comb begin
        upd_entry_d = upd_rd;
        if (upd_hit) begin
            upd_entry_d.ctr = upd_ctr_next;
            if (upd_taken) begin
                // Always retarget: a jalr may land somewhere new each time.
                upd_entry_d.target = target_EX;
                upd_entry_d.jump   = jump_EX;
            end
        end else begin
            upd_entry_d.valid  = 1'b1;
            upd_entry_d.tag    = upd_tag;
            upd_entry_d.target = target_EX;
            upd_entry_d.jump   = jump_EX;
            upd_entry_d.ctr    = jump_EX ? CTR_ST : CTR_WT;
        end
    end

    // ---------------- table storage ----------------
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            btb_entry_t entry_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q.valid <= 1'b0;
                    entry_q.ctr   <= CTR_RST;
                end else if (upd_wr_en && (upd_idx == IDX_W'(gi))) begin
                    entry_q <= upd_entry_d;
                end
            end

            assign table_rd[gi] = entry_q;
        end
    endgenerate

`ifdef BTB_STATS_EN
    // ---------------- statistics ----------------
    logic [31:0] stat_upd_q,   stat_upd_d;
    logic [31:0] stat_hit_q,   stat_hit_d;
    logic [31:0] stat_alloc_q, stat_alloc_d;

    always_comb begin
        stat_upd_d   = stat_upd_q   + {31'd0, upd_valid_EX};
        stat_hit_d   = stat_hit_q   + {31'd0, upd_valid_EX & upd_hit};
        stat_alloc_d = stat_alloc_q + {31'd0, upd_alloc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_upd_q   <= 32'd0;
            stat_hit_q   <= 32'd0;
            stat_alloc_q <= 32'd0;
        end else begin
            stat_upd_q   <= stat_upd_d;
            stat_hit_q   <= stat_hit_d;
            stat_alloc_q <= stat_alloc_d;
        end
    end

    assign stat_upd   = stat_upd_q;
    assign stat_hit   = stat_hit_q;
    assign stat_alloc = stat_alloc_q;
`else
    logic unused_alloc;
    assign unused_alloc = upd_alloc;
`endif

    // Byte offset bits play no part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_IF[1:0], pc_EX[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_IF;
    logic        hit_IF, taken_IF;
    logic [31:0] nextpc_IF;
    logic        upd_valid_EX;
    logic [31:0] pc_EX;
    logic        jump_EX, btaken_EX;
    logic [31:0] target_EX;
`ifdef BTB_STATS_EN
    logic [31:0] stat_upd, stat_hit, stat_alloc;
`endif

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_IF        (pc_IF),
        .hit_IF       (hit_IF),
        .taken_IF     (taken_IF),
        .nextpc_IF    (nextpc_IF),
        .upd_valid_EX (upd_valid_EX),
        .pc_EX        (pc_EX),
        .jump_EX      (jump_EX),
        .btaken_EX    (btaken_EX),
        .target_EX    (target_EX)
`ifdef BTB_STATS_EN
        ,
        .stat_upd     (stat_upd),
        .stat_hit     (stat_hit),
        .stat_alloc   (stat_alloc)
`endif
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Plain arrays indexed by (pc/4) mod N, tag = pc / (4*N).
    bit          m_valid [N];
    int unsigned m_tag   [N];
    bit [31:0]   m_tgt   [N];
    bit          m_jump  [N];
    int          m_ctr   [N];
    int unsigned m_upd = 0, m_hit = 0, m_alloc = 0;

    function automatic int midx(input bit [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic int unsigned mtag(input bit [31:0] pc);
        return pc / (4 * N);
    endfunction

    task automatic model_lookup(input bit r, input bit [31:0] pc,
                                output bit h, output bit t, output bit [31:0] npc);
        int i;
        i   = midx(pc);
        h   = !r && m_valid[i] && (m_tag[i] == mtag(pc));
        t   = h && (m_jump[i] || m_ctr[i] >= 2);
        npc = t ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_clock(input bit r, input bit u, input bit [31:0] pc,
                               input bit j, input bit b, input bit [31:0] tgt);
        int  i;
        bit  h, tk;
        if (r) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 1;
            end
            m_upd = 0; m_hit = 0; m_alloc = 0;
            return;
        end
        if (!u) return;
        i  = midx(pc);
        h  = m_valid[i] && (m_tag[i] == mtag(pc));
        tk = j || b;
        m_upd++;
        if (h) begin
            m_hit++;
            if (tk) begin
                m_ctr[i]  = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i]  = tgt;
                m_jump[i] = j;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (tk) begin
            m_alloc++;
            m_valid[i] = 1;
            m_tag[i]   = mtag(pc);
            m_tgt[i]   = tgt;
            m_jump[i]  = j;
            m_ctr[i]   = j ? 3 : 2;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit [31:0] pci, input bit u, input bit [31:0] pce,
                         input bit j, input bit b, input bit [31:0] tgt);
        @(negedge clk);
        rst = r; pc_IF = pci; upd_valid_EX = u; pc_EX = pce;
        jump_EX = j; btaken_EX = b; target_EX = tgt;
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit        rst;
        bit [31:0] pc_if;
        bit        upd;
        bit [31:0] pc_ex;
        bit        jmp;
        bit        bt;
        bit [31:0] tgt;
        bit        e_hit;
        bit        e_taken;
        bit [31:0] e_npc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        bit        eh, et;
        bit [31:0] enpc;
        bit        r, u, j, b;
        bit [31:0] pci, pce, tgt;

        rst = 1'b1; pc_IF = 0; upd_valid_EX = 0; pc_EX = 0;
        jump_EX = 0; btaken_EX = 0; target_EX = 0;

        //           rst pc_if         upd pc_ex      j  b  tgt          hit tk npc
        vecs[0]  = '{1, 32'h100,      0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104};
        vecs[1]  = '{1, 32'h100,      1, 32'h100, 0, 1, 32'h80,  0, 0, 32'h104};
        vecs[2]  = '{0, 32'h100,      0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104};
        vecs[3]  = '{0, 32'h100,      1, 32'h100, 0, 1, 32'h80,  0, 0, 32'h104};
        vecs[4]  = '{0, 32'h100,      1, 32'h100, 0, 0, 32'h0,   1, 1, 32'h80};
        vecs[5]  = '{0, 32'h100,      1, 32'h100, 0, 0, 32'h0,   1, 0, 32'h104};
        vecs[6]  = '{0, 32'h100,      1, 32'h100, 0, 0, 32'h0,   1, 0, 32'h104};
        vecs[7]  = '{0, 32'h100,      1, 32'h100, 0, 1, 32'h80,  1, 0, 32'h104};
        vecs[8]  = '{0, 32'h100,      0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h104};
        vecs[9]  = '{0, 32'h100,      1, 32'h140, 0, 1, 32'h180, 1, 0, 32'h104};
        vecs[10] = '{0, 32'h100,      0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104};
        vecs[11] = '{0, 32'h140,      0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h180};
        vecs[12] = '{0, 32'h200,      1, 32'h200, 1, 0, 32'h300, 0, 0, 32'h204};
        vecs[13] = '{0, 32'h200,      1, 32'h200, 1, 0, 32'h340, 1, 1, 32'h300};
        vecs[14] = '{0, 32'h200,      0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h340};
        vecs[15] = '{0, 32'hFFFFFFFC, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0};
        vecs[16] = '{0, 32'h202,      0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h340};
        vecs[17] = '{1, 32'h200,      0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h204};
        vecs[18] = '{0, 32'h200,      0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h204};
        vecs[19] = '{0, 32'h140,      0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h144};

        for (int k = 0; k < N; k++) begin
            m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_jump[k] = 0; m_ctr[k] = 1;
        end

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].pc_if, vecs[i].upd, vecs[i].pc_ex,
                  vecs[i].jmp, vecs[i].bt, vecs[i].tgt);
            $display("vec %0d rst=%0d pc_IF=%h upd=%0d pc_EX=%h j=%0d b=%0d tgt=%h -> hit=%0d tk=%0d npc=%h",
                     i, vecs[i].rst, vecs[i].pc_if, vecs[i].upd, vecs[i].pc_ex, vecs[i].jmp,
                     vecs[i].bt, vecs[i].tgt, hit_IF, taken_IF, nextpc_IF);
            chk($sformatf("vec%0d_hit", i),   {31'd0, hit_IF},   {31'd0, vecs[i].e_hit});
            chk($sformatf("vec%0d_taken", i), {31'd0, taken_IF}, {31'd0, vecs[i].e_taken});
            chk($sformatf("vec%0d_nextpc", i), nextpc_IF, vecs[i].e_npc);
`ifdef BTB_STATS_EN
            if (i == 2) begin
                chk("rst_upd_stat_upd",   stat_upd,   32'd0);
                chk("rst_upd_stat_hit",   stat_hit,   32'd0);
                chk("rst_upd_stat_alloc", stat_alloc, 32'd0);
            end
`endif
            @(posedge clk);
            model_clock(vecs[i].rst, vecs[i].upd, vecs[i].pc_ex,
                        vecs[i].jmp, vecs[i].bt, vecs[i].tgt);
        end

        // ---------------- randomized phase ----------------
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 49) == 0);
            u   = ($urandom_range(0, 3) != 0);
            j   = ($urandom_range(0, 3) == 0);
            b   = $urandom_range(0, 1);
            tgt = $urandom;
            // Few tags per index so hits, aliasing and retraining all occur.
            pci = ($urandom_range(0, 2) << 6) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
            pce = ($urandom_range(0, 2) << 6) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) pce = pci;
            drive(r, pci, u, pce, j, b, tgt);
            model_lookup(r, pci, eh, et, enpc);
            $display("rnd %0d rst=%0d pc_IF=%h upd=%0d pc_EX=%h j=%0d b=%0d -> hit=%0d tk=%0d npc=%h",
                     n, r, pci, u, pce, j, b, hit_IF, taken_IF, nextpc_IF);
            chk("rnd_hit",    {31'd0, hit_IF},   {31'd0, eh});
            chk("rnd_taken",  {31'd0, taken_IF}, {31'd0, et});
            chk("rnd_nextpc", nextpc_IF, enpc);
`ifdef BTB_STATS_EN
            chk("rnd_stat_upd",   stat_upd,   m_upd);
            chk("rnd_stat_hit",   stat_hit,   m_hit);
            chk("rnd_stat_alloc", stat_alloc, m_alloc);
`endif
            @(posedge clk);
            model_clock(r, u, pce, j, b, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer that sits directly upstream of the IF stage and supplies the next fetch PC. Each cycle it looks up the current fetch PC and returns a predicted redirect target for taken branches, `jal` and `jalr`. It is trained by resolved control-flow results from the EX stage. It replaces the direction-only prediction path, so IF can redirect without waiting for EX to compute the target.

## Interface
Parameters:
- `ENTRIES`, default 16: number of table entries; must be a power of two and at least 2.
- `IDX_W`, default `$clog2(ENTRIES)`: index width; derived, not overridden.
- `TAG_W`, default `30-IDX_W`: tag width; derived.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `pc_IF`  in  32  current fetch PC.
- `hit_IF`  out  1  a valid entry matches `pc_IF`.
- `taken_IF`  out  1  predict redirect.
- `nextpc_IF`  out  32  `target` if `taken_IF`, else `pc_IF+4`.
- `upd_valid_EX`  in  1  a resolved branch, `jal` or `jalr` is in EX this cycle.
- `pc_EX`  in  32  PC of the resolved instruction.
- `jump_EX`  in  1  1 = `jal`/`jalr` (unconditional), 0 = conditional branch.
- `btaken_EX`  in  1  resolved direction; ignored when `jump_EX` = 1.
- `target_EX`  in  32  resolved target address.

## Operation
- Address split:
  - index = `pc[IDX_W+1:2]`
  - tag = `pc[31:IDX_W+2]`
  - `pc[1:0]` is ignored.
- Entry fields: `valid`, `tag`, `target[31:0]`, `jump`, `ctr[1:0]`.
- Lookup is purely combinational:
  - `hit_IF` = `valid[idx] & (tag[idx]==tag(pc_IF))`
  - `taken_IF` = `hit_IF & (jump[idx] | ctr[idx][1])`
- Update, applied at the clock edge when `upd_valid_EX` = 1. Let "taken" = `jump_EX | btaken_EX`.
  - Hit, taken: `ctr` increments, saturating at 3. `target` ← `target_EX`; `jalr` retargeting always overwrites. `jump` ← `jump_EX`.
  - Hit, not taken: `ctr` decrements, saturating at 0. `target` is unchanged.
  - Miss, taken: allocate or replace the entry. `valid`=1, `tag`, `target` and `jump` are written. `ctr` = 2'b11 if `jump_EX`, else 2'b10.
  - Miss, not taken: no write.
- The `+4` adder is 32-bit and wraps modulo 2^32 (0xFFFFFFFC → 0x00000000).

## Timing
- Lookup latency: 0 cycles, combinational from `pc_IF`.
- Update latency: 1 cycle. The write is visible to a lookup in the cycle after `upd_valid_EX`.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents, with no bypass.
- No handshake. Stall and flush are handled outside the block. An update presented during an IF stall is still applied.
- Reset values:
  - all `valid` = 0 and all `ctr` = 2'b01, cleared in one cycle.
  - `tag` and `target` are not reset.
  - While and after reset: `hit_IF`=0, `taken_IF`=0, `nextpc_IF`=`pc_IF+4`.
- `rst` asserted together with `upd_valid_EX`: reset wins and the update is dropped.

## Configuration
- `BTB_STATS_EN` defined: the block adds three output ports, each a 32-bit wrapping counter reset to 0.
  - `stat_upd`: counts cycles with `upd_valid_EX`.
  - `stat_hit`: counts updates that hit.
  - `stat_alloc`: counts allocations.
- `BTB_STATS_EN` undefined: these ports and counters do not exist, and the behaviour of all other ports is identical.

## Structure
- Shared package `btb_pkg`:
  - `btb_entry_t` struct (`valid`, `tag`, `target`, `jump`, `ctr`)
  - `CTR_WT` = 2'b10, `CTR_ST` = 2'b11, `CTR_RST` = 2'b01
  - function `sat_update(ctr, taken)`
- One sub-module, `btb_sat_counter`: the combinational 2-bit saturating next-state logic, instanced once in the update path.
- The table is a flop array so that reset is single-cycle.

## Test plan
- Reset, then `pc_IF`=0x100 → `hit_IF`=0, `taken_IF`=0, `nextpc_IF`=0x104.
- Update `pc_EX`=0x100, `jump_EX`=0, `btaken_EX`=1, `target_EX`=0x80; next cycle `pc_IF`=0x100 → `hit_IF`=1, `taken_IF`=1, `nextpc_IF`=0x80 (ctr=2).
- Same entry: two not-taken updates → ctr 2→1→0, `taken_IF`=0, `nextpc_IF`=0x104. A third not-taken update keeps ctr=0, with no underflow.
- Aliasing with `ENTRIES`=16: allocate 0x100, then a taken update at 0x140 (same index, new tag) → 0x100 misses and 0x140 hits with the new target.
- `jalr` at 0x200: a `jump_EX` update with target 0x300, then one with target 0x340 → `nextpc_IF`=0x340. Lookup in the same cycle as the second update returns 0x300.
- Assert `rst` together with `upd_valid_EX` → no allocation occurs. With `BTB_STATS_EN` defined, all three stat counters read 0.
